mul_arbiter: RTL and testbench

- Shares one 32x32 signed pipelined multiplier (4-cycle latency, no reset, no stall) between NREQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle through a registered operand stage.
- A valid/ID tag pipeline, aligned to the multiplier latency, routes each 64-bit product back to its originator.
- Sits between the ray-setup/traversal units and the shared multiplier instance.

---
 rtl/mul_arbiter.sv | 108 ++++++++++
 tb/tb_mul_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin front end for one shared 32x32 signed pipelined multiplier.
// Grants at most one requester per cycle, registers its operands into the
// multiplier and carries a valid/ID tag alongside the product so the result
// can be steered back to its originator.
module mul_arbiter #(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned MUL_LATENCY = 4,
   parameter int unsigned ID_W        = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      res_valid,
   output logic [ID_W-1:0]      res_id,
   output logic [63:0]          res_p,
   output logic [31:0]          mul_a,
   output logic [31:0]          mul_b,
   input  logic [63:0]          mul_p,
   output logic                 busy,
   output logic [31:0]          issue_count
);

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  gnt_idx;
   logic [ID_W-1:0]  cand_id;
   logic             gnt_found;
   logic             transfer;
   int               cand;
   logic [31:0]      sel_a;
   logic [31:0]      sel_b;

   // Tag stage i describes the operation that entered the multiplier i edges ago.
   logic [MUL_LATENCY:0] tag_valid;
   logic [ID_W-1:0]      tag_id [MUL_LATENCY+1];

   // Search rr_ptr+1, rr_ptr+2, ... wrapping at NREQ (not 2^ID_W) for the first valid.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      cand_id   = '0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         cand    = (int'(rr_ptr) + k) % int'(NREQ);
         cand_id = cand[ID_W-1:0];
         if (!gnt_found && req_valid[cand_id]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_id;
         end
      end
   end

   // One-hot ready; suppressed during reset so nothing is accepted then.
   always_comb begin
      req_ready = '0;
      transfer  = gnt_found && !rst;
      if (transfer) begin
         req_ready[gnt_idx] = 1'b1;
      end
      sel_a = req_a[int'(gnt_idx)*32 +: 32];
      sel_b = req_b[int'(gnt_idx)*32 +: 32];
   end

   // Operand register, round-robin pointer and accepted-request counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_a       <= '0;
         mul_b       <= '0;
         rr_ptr      <= ID_W'(NREQ - 1);
         issue_count <= '0;
      end else if (transfer) begin
         mul_a       <= sel_a;
         mul_b       <= sel_b;
         rr_ptr      <= gnt_idx;
         issue_count <= issue_count + 32'd1;
      end
   end

   // Tag pipeline shifts every cycle; the multiplier cannot stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_valid <= '0;
         for (int i = 0; i <= int'(MUL_LATENCY); i++) begin
            tag_id[i] <= '0;
         end
      end else begin
         tag_valid <= {tag_valid[MUL_LATENCY-1:0], transfer};
         tag_id[0] <= gnt_idx;
         for (int i = 1; i <= int'(MUL_LATENCY); i++) begin
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

   // Result steering: last tag stage lines up with the multiplier output.
   always_comb begin
      res_valid = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         res_valid[i] = tag_valid[MUL_LATENCY] && (tag_id[MUL_LATENCY] == ID_W'(i));
      end
      res_id = tag_id[MUL_LATENCY];
      res_p  = mul_p;
      busy   = |tag_valid;
   end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural 4-stage multiplier.
module tb_mul_arbiter;

   logic          clk;
   logic          rst;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [127:0]  req_a;
   logic [127:0]  req_b;
   logic [3:0]    res_valid;
   logic [1:0]    res_id;
   logic [63:0]   res_p;
   logic [31:0]   mul_a;
   logic [31:0]   mul_b;
   logic [63:0]   mul_p;
   logic          busy;
   logic [31:0]   issue_count;

   mul_arbiter #(
      .NREQ        (4),
      .MUL_LATENCY (4),
      .ID_W        (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .res_valid   (res_valid),
      .res_id      (res_id),
      .res_p       (res_p),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_p       (mul_p),
      .busy        (busy),
      .issue_count (issue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External multiplier: unreset, 4 edges from a/b to p.
   logic [63:0] mpipe [4];
   always @(posedge clk) begin
      mpipe[0] <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
      mpipe[1] <= mpipe[0];
      mpipe[2] <= mpipe[1];
      mpipe[3] <= mpipe[2];
   end
   assign mul_p = mpipe[3];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]   valid;
      logic [3:0]   ready;
      logic [127:0] a;
      logic [127:0] b;
   } vec_t;

   typedef struct {
      int          id;
      logic [63:0] p;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   issue_exp = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] r,
                               input logic [31:0] a3, input logic [31:0] a2,
                               input logic [31:0] a1, input logic [31:0] a0,
                               input logic [31:0] b3, input logic [31:0] b2,
                               input logic [31:0] b1, input logic [31:0] b0);
      vec_t t;
      t.valid = v;
      t.ready = r;
      t.a     = {a3, a2, a1, a0};
      t.b     = {b3, b2, b1, b0};
      return t;
   endfunction

   function automatic vec_t idle();
      return mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   // Drive one cycle of requests, check the grant, push the expected result.
   task automatic step(input vec_t v);
      logic [31:0] pre_a;
      logic [31:0] pre_b;
      int          g;
      int          sa;
      int          sb_v;
      exp_t        e;
      req_valid = v.valid;
      req_a     = v.a;
      req_b     = v.b;
      #1;
      check("req_ready", {60'd0, req_ready}, {60'd0, v.ready});
      g = -1;
      for (int i = 0; i < 4; i++) if (v.ready[i]) g = i;
      if (g >= 0) begin
         sa    = int'(v.a[32*g +: 32]);
         sb_v  = int'(v.b[32*g +: 32]);
         e.id  = g;
         e.p   = 64'(longint'(sa) * longint'(sb_v));
         e.cyc = cyc + 5;
         sb.push_back(e);
      end
      pre_a = mul_a;
      pre_b = mul_b;
      @(posedge clk);
      #1;
      if (g >= 0) begin
         issue_exp++;
         check("mul_a", {32'd0, mul_a}, {32'd0, v.a[32*g +: 32]});
         check("mul_b", {32'd0, mul_b}, {32'd0, v.b[32*g +: 32]});
         check("issue_count", {32'd0, issue_count}, 64'(issue_exp));
      end else begin
         check("mul_a hold", {32'd0, mul_a}, {32'd0, pre_a});
         check("mul_b hold", {32'd0, mul_b}, {32'd0, pre_b});
      end
   endtask

   // Result monitor: results must appear exactly on their expected cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         check("res_valid", {60'd0, res_valid}, {60'd0, 4'b0001 << e.id});
         check("res_id", {62'd0, res_id}, 64'(e.id));
         check("res_p", res_p, e.p);
      end else begin
         check("res_valid idle", {60'd0, res_valid}, 64'd0);
      end
   end

   vec_t tbl[$];

   initial begin
      logic [31:0] bc;
      // Grant rotation with everyone valid (rr_ptr starts at 3 after reset).
      for (int c = 0; c < 8; c++) begin
         bc = 32'(10 * c);
         tbl.push_back(mk(4'b1111, 4'b0001 << (c % 4), 32'd4, 32'd3, 32'd2, 32'd1,
                          bc, bc, bc, bc));
      end
      tbl.push_back(idle());
      // Multiplier extremes.
      tbl.push_back(mk(4'b0001, 4'b0001, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h8000_0000));
      tbl.push_back(mk(4'b0010, 4'b0010, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 32'h8000_0000, 0));
      // Sparse: lone req 1, then 0 and 3 with rr_ptr=1 -> 3 first, then 0.
      tbl.push_back(mk(4'b0010, 4'b0010, 0, 0, 32'd5, 0, 0, 0, 32'd6, 0));
      tbl.push_back(mk(4'b1001, 4'b1000, 32'(-9), 0, 0, 32'd11, 32'd9, 0, 0, 32'(-2)));
      tbl.push_back(mk(4'b0001, 4'b0001, 0, 0, 0, 32'd11, 0, 0, 0, 32'(-2)));
      for (int i = 0; i < 6; i++) tbl.push_back(idle());

      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rst       = 1'b0;
      #1 rst    = 1'b1;
      req_valid = 4'b1111;
      @(posedge clk);
      #1;
      check("ready in reset", {60'd0, req_ready}, 64'd0);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset issue_count", {32'd0, issue_count}, 64'd0);
      check("reset mul_a", {32'd0, mul_a}, 64'd0);
      check("reset mul_b", {32'd0, mul_b}, 64'd0);
      check("reset res_id", {62'd0, res_id}, 64'd0);
      req_valid = '0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single request from requester 2; busy high for exactly 5 cycles.
      step(mk(4'b0100, 4'b0100, 0, 32'd7, 0, 0, 0, 32'(-3), 0, 0));
      check("busy k0", {63'd0, busy}, 64'd1);
      for (int k = 1; k <= 6; k++) begin
         step(idle());
         check("busy window", {63'd0, busy}, (k < 5) ? 64'd1 : 64'd0);
      end

      // Reset pulse to return rr_ptr to 3 before the table.
      rst = 1'b1;
      issue_exp = 0;
      @(posedge clk);
      #1 rst = 1'b0;

      foreach (tbl[i]) step(tbl[i]);

      // Held request: req 1 waits one cycle behind req 0, operands held.
      step(mk(4'b1000, 4'b1000, 32'd1, 0, 0, 0, 32'd1, 0, 0, 0));
      step(mk(4'b0011, 4'b0001, 0, 0, 32'(-1234), 32'd100, 0, 0, 32'd567, 32'd2));
      step(mk(4'b0011, 4'b0010, 0, 0, 32'(-1234), 32'd200, 0, 0, 32'd567, 32'd3));
      step(mk(4'b0001, 4'b0001, 0, 0, 0, 32'd300, 0, 0, 0, 32'd4));
      for (int i = 0; i < 6; i++) step(idle());

      // Reset with three operations in flight.
      step(mk(4'b0010, 4'b0010, 0, 0, 32'd21, 0, 0, 0, 32'd2, 0));
      step(mk(4'b0100, 4'b0100, 0, 32'd22, 0, 0, 0, 32'd3, 0, 0));
      step(mk(4'b1000, 4'b1000, 32'd23, 0, 0, 0, 32'd4, 0, 0, 0));
      rst = 1'b1;
      sb.delete();
      issue_exp = 0;
      req_valid = 4'b1111;
      #1;
      check("mid reset ready", {60'd0, req_ready}, 64'd0);
      check("mid reset busy", {63'd0, busy}, 64'd0);
      check("mid reset issue_count", {32'd0, issue_count}, 64'd0);
      check("mid reset res_valid", {60'd0, res_valid}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      // All valid -> requester 0 wins only if rr_ptr came back as 3.
      step(mk(4'b1111, 4'b0001, 32'd4, 32'd3, 32'd2, 32'd13, 0, 0, 0, 32'd5));
      for (int i = 0; i < 7; i++) step(idle());

      check("scoreboard drained", 64'(sb.size()), 64'd0);
      check("final busy", {63'd0, busy}, 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
